// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x-oversampled UART receiver, 5-8 data bits, optional parity,
// reporting parity/framing/break status alongside each received character.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling at cnt 6/7/8.
`timescale 1ns/1ps
module uart_rx_top (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic [1:0] wls,
   output logic       push,
   output logic [7:0] dout,
   output logic       pe,
   output logic       fe,
   output logic       bi
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] SAMPLE_CNT = 4'd8;
`else
   localparam logic [3:0] SAMPLE_CNT = 4'd7;
`endif
   localparam logic [3:0] WRAP_CNT = 4'd15;

   state_t     state;
   logic       rx_meta;
   logic       rxs;
   logic       armed;
   logic [3:0] cnt;
   logic [2:0] bitcnt;
   logic [7:0] sr;
   logic       par_bit;

   logic       bit_c;
   logic       sample_c;
   logic       wrap_c;
   logic [7:0] data_c;
   logic       exp_par_c;
   logic       pe_c;
   logic       bi_c;

   // Two-flop synchroniser on the asynchronous serial input, idling high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic s6;
   logic s7;

   // Capture the early samples of each bit for the 2-of-3 vote at cnt 8
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s6 <= 1'b1;
         s7 <= 1'b1;
      end else if (baud_pulse) begin
         if (cnt == 4'd6) s6 <= rxs;
         if (cnt == 4'd7) s7 <= rxs;
      end
   end

   assign bit_c = (s6 & s7) | (s6 & rxs) | (s7 & rxs);
`else
   assign bit_c = rxs;
`endif

   assign sample_c = baud_pulse && (cnt == SAMPLE_CNT);
   assign wrap_c   = baud_pulse && (cnt == WRAP_CNT);

   // Right-justify the shift register by word length; upper bits fill with 0
   assign data_c = sr >> (2'd3 - wls);

   // Expected parity bit from the LCR parity mode
   always_comb begin
      exp_par_c = 1'b0;
      case ({sticky_parity, eps})
         2'b00:   exp_par_c = ~(^data_c);
         2'b01:   exp_par_c = ^data_c;
         2'b10:   exp_par_c = 1'b1;
         default: exp_par_c = 1'b0;
      endcase
   end

   assign pe_c = pen & (par_bit != exp_par_c);
   assign bi_c = ~bit_c & (data_c == 8'd0) & (~pen | ~par_bit);

   // Receive state machine, bit timing and registered character outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         armed   <= 1'b0;
         cnt     <= 4'd0;
         bitcnt  <= 3'd0;
         sr      <= 8'd0;
         par_bit <= 1'b0;
         push    <= 1'b0;
         dout    <= 8'd0;
         pe      <= 1'b0;
         fe      <= 1'b0;
         bi      <= 1'b0;
      end else begin
         push <= 1'b0;
         if (baud_pulse) cnt <= cnt + 4'd1;
         case (state)
            IDLE: begin
               if (baud_pulse) begin
                  if (rxs) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     armed <= 1'b0;
                     cnt   <= 4'd0;
                     state <= START;
                  end
               end
            end
            START: begin
               if (sample_c && bit_c) begin
                  state <= IDLE;
               end else if (wrap_c) begin
                  bitcnt <= {1'b1, wls};
                  state  <= DATA;
               end
            end
            DATA: begin
               if (sample_c) sr <= {bit_c, sr[7:1]};
               if (wrap_c) begin
                  if (bitcnt == 3'd0) state <= pen ? PARITY : STOP;
                  else                bitcnt <= bitcnt - 3'd1;
               end
            end
            PARITY: begin
               if (sample_c) par_bit <= bit_c;
               if (wrap_c)   state   <= STOP;
            end
            STOP: begin
               if (sample_c) begin
                  push  <= 1'b1;
                  dout  <= data_c;
                  pe    <= pe_c;
                  fe    <= ~bit_c;
                  bi    <= bi_c;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: vector table of frames plus hand-built
// glitch, break, reset and majority-sampling sequences, with an expected-push queue.
`timescale 1ns/1ps
module tb_uart_rx_top;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       baud_pulse = 1'b0;
   logic       rx = 1'b1;
   logic       pen = 1'b0;
   logic       eps = 1'b0;
   logic       sticky_parity = 1'b0;
   logic [1:0] wls = 2'd3;
   logic       push;
   logic [7:0] dout;
   logic       pe;
   logic       fe;
   logic       bi;

   uart_rx_top dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
      .pen(pen), .eps(eps), .sticky_parity(sticky_parity), .wls(wls),
      .push(push), .dout(dout), .pe(pe), .fe(fe), .bi(bi)
   );

   always #5 clk = ~clk;

   // 16x strobe: one clk high every four, changing on the falling edge
   initial begin
      forever begin
         repeat (3) @(negedge clk);
         baud_pulse = 1'b1;
         @(negedge clk);
         baud_pulse = 1'b0;
      end
   end

   typedef struct {
      logic [1:0] wls;
      logic       pen;
      logic       eps;
      logic       stick;
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [7:0] e_dout;
      logic       e_pe;
      logic       e_fe;
      logic       e_bi;
   } vec_t;

   typedef struct {
      logic [7:0] dout;
      logic       pe;
      logic       fe;
      logic       bi;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   checks = 0;
   int   failures = 0;
   int   push_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic expect_char(input logic [7:0] d, input logic p, input logic f, input logic b);
      exp_t e;
      e.dout = d; e.pe = p; e.fe = f; e.bi = b;
      sb.push_back(e);
   endtask

   // Advance one clock and score any push against the queue head
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (push) begin
         push_seen++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_push: got push=1 (dout=%0h) expected no push", dout);
         end else begin
            e = sb.pop_front();
            check("dout", 32'(dout), 32'(e.dout));
            check("pe",   32'(pe),   32'(e.pe));
            check("fe",   32'(fe),   32'(e.fe));
            check("bi",   32'(bi),   32'(e.bi));
         end
      end
   endtask

   task automatic wait_pulses(input int n);
      int k;
      k = 0;
      while (k < n) begin
         step();
         if (baud_pulse) k++;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic [1:0] w,
                             input logic p_en, input logic par, input logic stop);
      rx = 1'b0;
      wait_pulses(16);
      for (int i = 0; i < int'(w) + 5; i++) begin
         rx = data[3'(i)];
         wait_pulses(16);
      end
      if (p_en) begin
         rx = par;
         wait_pulses(16);
      end
      rx = stop;
      wait_pulses(16);
      rx = 1'b1;
      wait_pulses(4);
   endtask

   task automatic set_lcr(input logic [1:0] w, input logic p_en, input logic e, input logic s);
      wls = w; pen = p_en; eps = e; sticky_parity = s;
   endtask

   initial begin
      int   base;
      vec_t v;

      vecs[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{2'd3, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{2'd3, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{2'd1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{2'd0, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hF5, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};

      // Reset values
      rst = 1'b0;
      rx  = 1'b1;
      repeat (4) step();
      check("rst_push", 32'(push), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_pe",   32'(pe),   32'd0);
      check("rst_fe",   32'(fe),   32'd0);
      check("rst_bi",   32'(bi),   32'd0);
      rst = 1'b1;
      wait_pulses(8);

      // Table-driven frames
      for (int i = 0; i < 12; i++) begin
         v = vecs[i];
         set_lcr(v.wls, v.pen, v.eps, v.stick);
         base = push_seen;
         expect_char(v.e_dout, v.e_pe, v.e_fe, v.e_bi);
         send_frame(v.data, v.wls, v.pen, v.par, v.stop);
         check("vec_push_count", 32'(push_seen - base), 32'd1);
         sb.delete();
      end

      // Short low glitch is rejected, following 5N1 frame is received
      set_lcr(2'd0, 1'b0, 1'b0, 1'b0);
      base = push_seen;
      rx = 1'b0;
      wait_pulses(4);
      rx = 1'b1;
      wait_pulses(20);
      check("glitch_no_push", 32'(push_seen - base), 32'd0);
      expect_char(8'h1F, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1F, 2'd0, 1'b0, 1'b0, 1'b1);
      check("glitch_frame_push", 32'(push_seen - base), 32'd1);
      sb.delete();

      // Held break gives exactly one push until the line returns high
      set_lcr(2'd3, 1'b1, 1'b1, 1'b0);
      base = push_seen;
      expect_char(8'h00, 1'b0, 1'b1, 1'b1);
      rx = 1'b0;
      wait_pulses(3 * 11 * 16);
      check("break_push_count", 32'(push_seen - base), 32'd1);
      rx = 1'b1;
      wait_pulses(20);
      check("break_no_repeat", 32'(push_seen - base), 32'd1);
      expect_char(8'h66, 1'b0, 1'b0, 1'b0);
      send_frame(8'h66, 2'd3, 1'b1, 1'b0, 1'b1);
      check("break_next_push", 32'(push_seen - base), 32'd2);
      sb.delete();

      // Leave non-zero status, then reset during data bit 3 of 0x5A
      set_lcr(2'd3, 1'b1, 1'b1, 1'b1);
      expect_char(8'hC3, 1'b1, 1'b1, 1'b0);
      send_frame(8'hC3, 2'd3, 1'b1, 1'b1, 1'b0);
      sb.delete();
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0);
      base = push_seen;
      rx = 1'b0;
      wait_pulses(16);
      rx = 1'b0; wait_pulses(16);
      rx = 1'b1; wait_pulses(16);
      rx = 1'b0; wait_pulses(16);
      rx = 1'b1; wait_pulses(8);
      rst = 1'b0;
      step();
      step();
      check("midrst_push", 32'(push), 32'd0);
      check("midrst_dout", 32'(dout), 32'd0);
      check("midrst_pe",   32'(pe),   32'd0);
      check("midrst_fe",   32'(fe),   32'd0);
      check("midrst_bi",   32'(bi),   32'd0);
      step();
      rst = 1'b1;
      wait_pulses(24);
      check("midrst_no_push", 32'(push_seen - base), 32'd0);
      expect_char(8'h5A, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b1);
      check("midrst_next_push", 32'(push_seen - base), 32'd1);
      sb.delete();

      // One-pulse high glitch at the cnt 7 sample of data bit 0 of 0x00
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0);
      base = push_seen;
`ifdef UART_RX_MAJORITY_EN
      expect_char(8'h00, 1'b0, 1'b0, 1'b0);
`else
      expect_char(8'h01, 1'b0, 1'b0, 1'b0);
`endif
      rx = 1'b0;
      wait_pulses(16);
      rx = 1'b0;
      wait_pulses(8);
      rx = 1'b1;
      wait_pulses(1);
      rx = 1'b0;
      wait_pulses(7);
      for (int i = 1; i < 8; i++) begin
         rx = 1'b0;
         wait_pulses(16);
      end
      rx = 1'b1;
      wait_pulses(20);
      check("majority_push_count", 32'(push_seen - base), 32'd1);
      sb.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
